cascade_updown_cntr: RTL and testbench
======================================

Name: cascade_updown_cntr

Overview:
Parametrised successor to the single-digit controlled counter. It chains DIGITS modulo-(N+1) digit cells into one multi-digit counter, for example BCD with N=9. The counter supports up and down counting, synchronous clear, and parallel load with per-digit clamping. Whole-chain wrap is flagged by one-cycle expired and underflow pulses. It feeds display/score logic in the lab top-levels.

Parameters:
WIDTH, 4, bits per digit; must hold unsigned N (2**WIDTH > N)
N, 9, maximum value of each digit; each digit counts 0..N inclusive
DIGITS, 4, number of cascaded digits; digit 0 is least significant

Ports:
clk  input  1  system clock, all state updates on posedge
reset  input  1  asynchronous, active-high reset; clears all state immediately, independent of clk
inc  input  1  increment request, synchronous to clk
dec  input  1  decrement request, synchronous to clk
clear  input  1  synchronous clear of all digits to 0
load  input  1  synchronous parallel load
load_val  input  DIGITS*WIDTH  load value; digit k occupies bits [k*WIDTH +: WIDTH]
count  output  DIGITS*WIDTH  current count, same packing as load_val
expired  output  1  one-cycle pulse: whole chain wrapped from all-N to all-0
underflow  output  1  one-cycle pulse: whole chain wrapped from all-0 to all-N

Behaviour:
- Reset (async, active-high): count=0, expired=0, underflow=0 at assertion, without waiting for a clock edge. While reset is held, everything stays at 0. Release takes effect at the next posedge.
- Priority per posedge: clear > load > (inc XOR dec) > hold.
- clear: count<=0; expired<=0; underflow<=0.
- load: each digit <= min(load_val digit, N), so an out-of-range digit clamps to N. Flags<=0.
- inc and dec both high, or both low: count holds; flags<=0.
- Up step (inc only):
  - digit 0 increments.
  - A digit at N wraps to 0 and carries into the next digit.
  - Digit k changes only if all lower digits are N.
- Down step (dec only):
  - digit 0 decrements.
  - A digit at 0 wraps to N and borrows from the next digit.
  - Digit k changes only if all lower digits are 0.
- expired: registered. It is 1 in the cycle after the edge at which count goes all-N -> all-0 on an up step, otherwise 0. It is asserted concurrently with count==0. It never stays high two cycles unless the chain wraps on two consecutive edges, which is impossible for DIGITS>=1 with N>=1.
- underflow: the same timing rule, for all-0 -> all-N on a down step.
- expired and underflow are never high simultaneously.
- Carry/borrow is computed combinationally within the cycle. Single-cycle latency from request to updated count.
- N=0 is legal: every digit is constantly 0, every inc pulses expired, and every dec pulses underflow.
- Reset asserted mid-step overrides any in-flight edge. No partial digit updates are visible.

Optional Feature:
Macro CASCADE_CNTR_SATURATE_EN.
- Defined:
  - Counter saturates instead of wrapping: inc at all-N holds all-N, and dec at all-0 holds all-0.
  - expired pulses for each rejected inc at all-N.
  - underflow pulses for each rejected dec at all-0.
  - A held request produces a pulse every cycle.
- Undefined: wrap-around behaviour as above. No saturation logic is synthesised.

Decomposition:
- Package cntr_pkg holds:
  - typedef enum logic [1:0] cntr_op_t {OP_HOLD, OP_UP, OP_DOWN, OP_LOAD} (OP_LOAD also covers clear).
  - A function that decodes {clear, load, inc, dec} into cntr_op_t with the priority above.
- Sub-module cntr_digit (WIDTH, N) holds:
  - Inputs: op, carry_in/borrow_in, load digit.
  - Outputs: digit value, carry_out (digit==N), borrow_out (digit==0).
- The top level instantiates DIGITS cells in a generate loop, ANDs the carry/borrow chain, and registers expired/underflow.

Test Plan:
All scenarios use WIDTH=4, N=9, DIGITS=2 (count shown as hex digits).
1. Assert reset between clock edges with count=0x37 -> count=0x00, expired=0, underflow=0 before the next posedge.
2. From 0x00, inc for 10 cycles -> 0x09 after 9 edges, 0x10 after 10 edges; expired stays 0.
3. load_val=0x98, load; then inc for 2 cycles -> 0x99, then 0x00 with expired=1 for exactly that one cycle; underflow=0.
4. From 0x00, dec for 1 cycle -> 0x99, underflow=1 for one cycle; a further dec -> 0x98, underflow=0.
5. inc=dec=1 at 0x45 -> hold at 0x45; load_val=0xAF -> 0x99 (clamped); clear and load together -> 0x00.
6. With CASCADE_CNTR_SATURATE_EN defined: at 0x99, hold inc for 3 cycles -> count stays 0x99, expired=1 each cycle.

Source files
------------

// File: rtl/cascade_updown_cntr_pkg.sv
// Shared types for the cascaded up/down counter: digit operation encoding and request decode.
// Optional saturation is controlled by CASCADE_CNTR_SATURATE_EN in the top level.
package cntr_pkg;

    // OP_LOAD doubles as clear: the top feeds an all-zero load word when clear is set.
    typedef enum logic [1:0] {
        OP_HOLD,
        OP_UP,
        OP_DOWN,
        OP_LOAD
    } cntr_op_t;

    // Priority: clear > load > (inc XOR dec) > hold.
    function automatic cntr_op_t decode_op(input logic clear, input logic load,
                                           input logic inc, input logic dec);
        if (clear || load)
            return OP_LOAD;
        else if (inc && !dec)
            return OP_UP;
        else if (dec && !inc)
            return OP_DOWN;
        else
            return OP_HOLD;
    endfunction

endpackage

// File: rtl/cascade_updown_cntr_if.sv
// Request/result bundle between a controller (master) and the cascaded counter (slave).
interface cascade_updown_cntr_if #(
    parameter int WIDTH  = 4,
    parameter int DIGITS = 4
);
    logic                    inc;
    logic                    dec;
    logic                    clear;
    logic                    load;
    logic [DIGITS*WIDTH-1:0] load_val;
    logic [DIGITS*WIDTH-1:0] count;
    logic                    expired;
    logic                    underflow;

    modport master (
        output inc, dec, clear, load, load_val,
        input  count, expired, underflow
    );

    modport slave (
        input  inc, dec, clear, load, load_val,
        output count, expired, underflow
    );
endinterface

// File: rtl/cascade_updown_cntr_digit.sv
// One modulo-(N+1) digit cell: loads with clamping to N, steps only when the lower chain enables it.
module cntr_digit
    import cntr_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int N     = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  cntr_op_t         i_op,
    input  logic             i_carry_in,
    input  logic             i_borrow_in,
    input  logic [WIDTH-1:0] i_load,
    output logic [WIDTH-1:0] o_digit,
    output logic             o_carry_out,
    output logic             o_borrow_out
);
    localparam logic [WIDTH-1:0] MAX_DIGIT = WIDTH'(N);

    logic [WIDTH-1:0] r_digit;

    // NOTE: non-blocking updates let every cell see the pre-edge carry/borrow chain, so no partial step is visible.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_digit <= '0;
        end else begin
            unique case (i_op)
                OP_LOAD: r_digit <= (i_load > MAX_DIGIT) ? MAX_DIGIT : i_load;
                OP_UP:   if (i_carry_in)
                             r_digit <= (r_digit == MAX_DIGIT) ? '0 : r_digit + 1'b1;
                OP_DOWN: if (i_borrow_in)
                             r_digit <= (r_digit == '0) ? MAX_DIGIT : r_digit - 1'b1;
                default: r_digit <= r_digit;
            endcase
        end
    end

    assign o_digit      = r_digit;
    assign o_carry_out  = (r_digit == MAX_DIGIT);
    assign o_borrow_out = (r_digit == '0);
endmodule

// File: rtl/cascade_updown_cntr.sv
// Multi-digit up/down counter built from cntr_digit cells with whole-chain wrap pulses.
// Define CASCADE_CNTR_SATURATE_EN to saturate at all-N / all-0 instead of wrapping.
module cascade_updown_cntr
    import cntr_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int N      = 9,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    cascade_updown_cntr_if.slave  bus
);
    cntr_op_t                w_op_req;
    cntr_op_t                w_op;
    logic [DIGITS:0]         w_carry;
    logic [DIGITS:0]         w_borrow;
    logic [DIGITS-1:0]       w_at_max;
    logic [DIGITS-1:0]       w_at_min;
    logic [DIGITS*WIDTH-1:0] w_load_word;
    logic [DIGITS*WIDTH-1:0] w_count;
    logic                    w_wrap_up;
    logic                    w_wrap_down;
    logic                    r_expired;
    logic                    r_underflow;

    assign w_op_req    = decode_op(bus.clear, bus.load, bus.inc, bus.dec);
    assign w_load_word = bus.clear ? '0 : bus.load_val;

    // Digit k steps only when every lower digit is at its wrap point.
    assign w_carry[0]  = 1'b1;
    assign w_borrow[0] = 1'b1;

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        cntr_digit #(
            .WIDTH (WIDTH),
            .N     (N)
        ) u_digit (
            .clk          (clk),
            .reset        (reset),
            .i_op         (w_op),
            .i_carry_in   (w_carry[k]),
            .i_borrow_in  (w_borrow[k]),
            .i_load       (w_load_word[k*WIDTH +: WIDTH]),
            .o_digit      (w_count[k*WIDTH +: WIDTH]),
            .o_carry_out  (w_at_max[k]),
            .o_borrow_out (w_at_min[k])
        );

        assign w_carry[k+1]  = w_carry[k]  & w_at_max[k];
        assign w_borrow[k+1] = w_borrow[k] & w_at_min[k];
    end

    assign w_wrap_up   = (w_op_req == OP_UP)   && w_carry[DIGITS];
    assign w_wrap_down = (w_op_req == OP_DOWN) && w_borrow[DIGITS];

`ifdef CASCADE_CNTR_SATURATE_EN
    // A step that would wrap the whole chain is turned into a hold; the pulse still fires.
    assign w_op = (w_wrap_up || w_wrap_down) ? OP_HOLD : w_op_req;
`else
    assign w_op = w_op_req;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_expired   <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_expired   <= w_wrap_up;
            r_underflow <= w_wrap_down;
        end
    end

    assign bus.count     = w_count;
    assign bus.expired   = r_expired;
    assign bus.underflow = r_underflow;
endmodule

// File: tb/tb_cascade_updown_cntr.sv
// Self-checking bench for cascade_updown_cntr (WIDTH=4, N=9, DIGITS=2) against an integer-valued model.
module tb_cascade_updown_cntr;
    localparam int WIDTH  = 4;
    localparam int N      = 9;
    localparam int DIGITS = 2;
    localparam int BASE   = N + 1;
    localparam int MAXV   = BASE ** DIGITS - 1;
    localparam int VW     = DIGITS * WIDTH;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cascade_updown_cntr_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

    cascade_updown_cntr #(
        .WIDTH  (WIDTH),
        .N      (N),
        .DIGITS (DIGITS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: the whole counter as one integer 0..MAXV.
    int   m_val;
    logic m_exp;
    logic m_unf;

    function automatic logic [VW-1:0] to_digits(input int v);
        logic [VW-1:0] r;
        int t;
        r = '0;
        t = v;
        for (int k = 0; k < DIGITS; k++) begin
            r[k*WIDTH +: WIDTH] = WIDTH'(t % BASE);
            t = t / BASE;
        end
        return r;
    endfunction

    function automatic int load_value(input logic [VW-1:0] lv);
        int v, scale, d;
        v = 0;
        scale = 1;
        for (int k = 0; k < DIGITS; k++) begin
            d = int'(lv[k*WIDTH +: WIDTH]);
            if (d > N) d = N;
            v += d * scale;
            scale *= BASE;
        end
        return v;
    endfunction

    task automatic model_step(input logic c, input logic l, input logic i, input logic d,
                              input logic [VW-1:0] lv);
        m_exp = 1'b0;
        m_unf = 1'b0;
        if (c) begin
            m_val = 0;
        end else if (l) begin
            m_val = load_value(lv);
        end else if (i && !d) begin
            if (m_val == MAXV) begin
                m_exp = 1'b1;
`ifndef CASCADE_CNTR_SATURATE_EN
                m_val = 0;
`endif
            end else begin
                m_val = m_val + 1;
            end
        end else if (d && !i) begin
            if (m_val == 0) begin
                m_unf = 1'b1;
`ifndef CASCADE_CNTR_SATURATE_EN
                m_val = MAXV;
`endif
            end else begin
                m_val = m_val - 1;
            end
        end
    endtask

    // Apply one cycle of request inputs, advance the model with the edge, sample 1 ns later.
    task automatic drive(input logic c, input logic l, input logic i, input logic d,
                         input logic [VW-1:0] lv);
        @(negedge clk);
        bus.clear    = c;
        bus.load     = l;
        bus.inc      = i;
        bus.dec      = d;
        bus.load_val = lv;
        @(posedge clk);
        model_step(c, l, i, d, lv);
        #1;
    endtask

    task automatic test_reset;
        #2;
        checks++;
        if (bus.count !== '0 || bus.expired !== 1'b0 || bus.underflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_initial: count=%h exp=%b unf=%b, required 00/0/0",
                     bus.count, bus.expired, bus.underflow);
        end
        @(negedge clk);
        reset = 1'b0;
        drive(0, 1, 0, 0, 8'h37);
        checks++;
        if (bus.count !== 8'h37) begin
            errors++;
            $display("FAIL reset_preload: count=%h, required 37", bus.count);
        end
        // Assert reset between edges; state must clear without a clock edge.
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.count !== '0 || bus.expired !== 1'b0 || bus.underflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: count=%h exp=%b unf=%b, required 00/0/0",
                     bus.count, bus.expired, bus.underflow);
        end
        @(negedge clk);
        bus.inc = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.count !== '0 || bus.expired !== 1'b0) begin
            errors++;
            $display("FAIL reset_held: count=%h exp=%b, required 00/0", bus.count, bus.expired);
        end
        @(negedge clk);
        bus.inc = 1'b0;
        reset   = 1'b0;
        m_val = 0;
        m_exp = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic test_inc_carry;
        drive(1, 0, 0, 0, '0);
        for (int i = 1; i <= 10; i++) begin
            drive(0, 0, 1, 0, '0);
            checks++;
            if (bus.count !== to_digits(m_val) || bus.expired !== 1'b0 || bus.underflow !== 1'b0) begin
                errors++;
                $display("FAIL inc_carry step %0d: count=%h exp=%b unf=%b, required %h/0/0",
                         i, bus.count, bus.expired, bus.underflow, to_digits(m_val));
            end
            if (i == 9 || i == 10) begin
                checks++;
                if (bus.count !== ((i == 9) ? 8'h09 : 8'h10)) begin
                    errors++;
                    $display("FAIL inc_carry_point %0d: count=%h, required %h",
                             i, bus.count, (i == 9) ? 8'h09 : 8'h10);
                end
            end
        end
    endtask

    task automatic test_wrap_up;
        logic [VW-1:0] exp_cnt;
        drive(0, 1, 0, 0, 8'h98);
        drive(0, 0, 1, 0, '0);
        checks++;
        if (bus.count !== 8'h99 || bus.expired !== 1'b0) begin
            errors++;
            $display("FAIL wrap_up_pre: count=%h exp=%b, required 99/0", bus.count, bus.expired);
        end
        drive(0, 0, 1, 0, '0);
`ifdef CASCADE_CNTR_SATURATE_EN
        exp_cnt = 8'h99;
`else
        exp_cnt = 8'h00;
`endif
        checks++;
        if (bus.count !== exp_cnt || bus.expired !== 1'b1 || bus.underflow !== 1'b0) begin
            errors++;
            $display("FAIL wrap_up_edge: count=%h exp=%b unf=%b, required %h/1/0",
                     bus.count, bus.expired, bus.underflow, exp_cnt);
        end
        drive(0, 0, 0, 0, '0);
        checks++;
        if (bus.count !== exp_cnt || bus.expired !== 1'b0) begin
            errors++;
            $display("FAIL wrap_up_after: count=%h exp=%b, required %h/0", bus.count, bus.expired, exp_cnt);
        end
    endtask

    task automatic test_wrap_down;
        drive(1, 0, 0, 0, '0);
        for (int i = 1; i <= 2; i++) begin
            drive(0, 0, 0, 1, '0);
            checks++;
            if (bus.count !== to_digits(m_val) || bus.underflow !== m_unf || bus.expired !== 1'b0) begin
                errors++;
                $display("FAIL wrap_down step %0d: count=%h unf=%b exp=%b, required %h/%b/0",
                         i, bus.count, bus.underflow, bus.expired, to_digits(m_val), m_unf);
            end
        end
`ifndef CASCADE_CNTR_SATURATE_EN
        checks++;
        if (bus.count !== 8'h98 || bus.underflow !== 1'b0) begin
            errors++;
            $display("FAIL wrap_down_point: count=%h unf=%b, required 98/0", bus.count, bus.underflow);
        end
`endif
    endtask

    task automatic test_hold_clamp;
        drive(0, 1, 0, 0, 8'h45);
        drive(0, 0, 1, 1, '0);
        checks++;
        if (bus.count !== 8'h45 || bus.expired !== 1'b0 || bus.underflow !== 1'b0) begin
            errors++;
            $display("FAIL both_hold: count=%h exp=%b unf=%b, required 45/0/0",
                     bus.count, bus.expired, bus.underflow);
        end
        drive(0, 1, 0, 0, 8'hAF);
        checks++;
        if (bus.count !== 8'h99) begin
            errors++;
            $display("FAIL load_clamp: count=%h, required 99", bus.count);
        end
        drive(1, 1, 1, 0, 8'h55);
        checks++;
        if (bus.count !== 8'h00 || bus.expired !== 1'b0) begin
            errors++;
            $display("FAIL clear_over_load: count=%h exp=%b, required 00/0", bus.count, bus.expired);
        end
    endtask

`ifdef CASCADE_CNTR_SATURATE_EN
    task automatic test_saturate;
        drive(0, 1, 0, 0, 8'h99);
        for (int i = 1; i <= 3; i++) begin
            drive(0, 0, 1, 0, '0);
            checks++;
            if (bus.count !== 8'h99 || bus.expired !== 1'b1) begin
                errors++;
                $display("FAIL saturate_hold %0d: count=%h exp=%b, required 99/1", i, bus.count, bus.expired);
            end
        end
    endtask
`endif

    task automatic test_random;
        logic c, l, i, d;
        logic [VW-1:0] lv;
        int r;
        for (int n = 0; n < 400; n++) begin
            r  = int'($urandom_range(0, 99));
            lv = VW'($urandom);
            c  = (r < 3);
            l  = (r >= 3 && r < 10);
            // Long inc-biased then dec-biased phases drive the chain through both wraps.
            if (n < 200) begin
                i = (r >= 10 && r < 80);
                d = (r >= 70);
            end else begin
                i = (r >= 70);
                d = (r >= 10 && r < 80);
            end
            drive(c, l, i, d, lv);
            checks++;
            if (bus.count !== to_digits(m_val) || bus.expired !== m_exp || bus.underflow !== m_unf) begin
                errors++;
                $display("FAIL random cyc %0d: count=%h exp=%b unf=%b, required %h/%b/%b",
                         n, bus.count, bus.expired, bus.underflow, to_digits(m_val), m_exp, m_unf);
            end
        end
    endtask

    initial begin
        reset        = 1'b1;
        bus.inc      = 1'b0;
        bus.dec      = 1'b0;
        bus.clear    = 1'b0;
        bus.load     = 1'b0;
        bus.load_val = '0;
        m_val = 0;
        m_exp = 1'b0;
        m_unf = 1'b0;

        test_reset();
        test_inc_carry();
        test_wrap_up();
        test_wrap_down();
        test_hold_clamp();
`ifdef CASCADE_CNTR_SATURATE_EN
        test_saturate();
`endif
        test_random();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
